// File: rtl/onewire_mc_pkg.sv
// rtl/onewire_mc_pkg.sv - 1-wire master command encodings, FSM states and slot timing
package onewire_mc_pkg;

  typedef enum logic [1:0] {
    TYP_BIT  = 2'b00,
    TYP_RST  = 2'b01,
    TYP_RSV2 = 2'b10,
    TYP_RSV3 = 2'b11
  } cmd_typ_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOW  = 2'b01,
    ST_REL  = 2'b10,
    ST_REC  = 2'b11
  } state_e;

  localparam int TW = 10;

  // Slot timing in ticks
  localparam logic [TW-1:0] T_LOW_W0   = 10'd60;
  localparam logic [TW-1:0] T_LOW_W1   = 10'd6;
  localparam logic [TW-1:0] T_SMP_BIT  = 10'd15;
  localparam logic [TW-1:0] T_SLOT_BIT = 10'd64;
  localparam logic [TW-1:0] T_LOW_RST  = 10'd480;
  localparam logic [TW-1:0] T_SMP_RST  = 10'd550;
  localparam logic [TW-1:0] T_SLOT_RST = 10'd960;

  function automatic logic typ_is_slot(input logic [1:0] typ);
    return (typ == TYP_BIT) || (typ == TYP_RST);
  endfunction

endpackage

// File: rtl/onewire_mc_if.sv
// rtl/onewire_mc_if.sv - command/response and line bundle of the 1-wire master
interface onewire_mc_if #(
  parameter int OWN = 4
);
  localparam int SW = (OWN > 1) ? $clog2(OWN) : 1;

  logic           cmd_vld;
  logic           cmd_rdy;
  logic [1:0]     cmd_typ;
  logic           cmd_dat;
  logic           cmd_ovd;
  logic           cmd_pwr;
  logic [SW-1:0]  cmd_sel;
  logic           rsp_vld;
  logic           rsp_dat;
  logic [OWN-1:0] owr_p;
  logic [OWN-1:0] owr_e;
  logic [OWN-1:0] owr_i;

  modport master (
    output cmd_vld, cmd_typ, cmd_dat, cmd_ovd, cmd_pwr, cmd_sel, owr_i,
    input  cmd_rdy, rsp_vld, rsp_dat, owr_p, owr_e
  );

  modport slave (
    input  cmd_vld, cmd_typ, cmd_dat, cmd_ovd, cmd_pwr, cmd_sel, owr_i,
    output cmd_rdy, rsp_vld, rsp_dat, owr_p, owr_e
  );

endinterface

// File: rtl/onewire_mc_tick.sv
// rtl/onewire_mc_tick.sv - tick strobe divider, standard or overdrive rate
module onewire_mc_tick #(
  parameter int CDR_N = 33,
  parameter int CDR_O = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic ovd,
  output logic tick
);
  localparam int DMAX = (CDR_N > CDR_O) ? CDR_N : CDR_O;
  localparam int CW   = (DMAX > 1) ? $clog2(DMAX) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] lim;

  assign lim  = ovd ? CW'(CDR_O - 1) : CW'(CDR_N - 1);
  assign tick = (cnt == lim);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/onewire_mc.sv
// rtl/onewire_mc.sv - multi-channel 1-wire master: bit and reset/presence slots
module onewire_mc
  import onewire_mc_pkg::*;
#(
  parameter int OWN   = 4,
  parameter int CDR_N = 33,
  parameter int CDR_O = 4
) (
  input  logic          clk,
  input  logic          rst,
  onewire_mc_if.slave   bus
);
  localparam int SW = (OWN > 1) ? $clog2(OWN) : 1;

  state_e         state;
  cmd_typ_e       typ_q;
  logic           dat_q;
  logic           ovd_q;
  logic           pwr_q;
  logic [SW-1:0]  sel_q;
  logic           sel_ok_q;
  logic [OWN-1:0] sel_mask_q;

  logic [TW-1:0]  tick_cnt;
  logic [TW-1:0]  low_end;
  logic [TW-1:0]  smp_pt;
  logic [TW-1:0]  slot_end;

  logic [OWN-1:0] sync1;
  logic [OWN-1:0] sync2;
  logic [OWN-1:0] owr_e_q;
  logic [OWN-1:0] owr_p_q;

  logic           smp_lvl;
  logic           pwr_go;
  logic           rsp_vld_q;
  logic           rsp_dat_q;
  logic           accept;
  logic           tick;
  logic           sel_ok_in;
  logic [OWN-1:0] sel_mask_in;
  logic           line;

  assign accept      = bus.cmd_vld && (state == ST_IDLE);
  assign sel_ok_in   = int'(bus.cmd_sel) < OWN;
  assign sel_mask_in = sel_ok_in ? (OWN'(1) << bus.cmd_sel) : '0;

  // An unselectable channel reads as an idle (high) line
  assign line = sel_ok_q ? sync2[sel_q] : 1'b1;

  always_comb begin
    low_end  = T_LOW_RST;
    smp_pt   = T_SMP_RST;
    slot_end = T_SLOT_RST;
    if (typ_q == TYP_BIT) begin
      low_end  = dat_q ? T_LOW_W1 : T_LOW_W0;
      smp_pt   = T_SMP_BIT;
      slot_end = T_SLOT_BIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.owr_i;
      sync2 <= sync1;
    end
  end

  onewire_mc_tick #(
    .CDR_N (CDR_N),
    .CDR_O (CDR_O)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .ovd  (ovd_q),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      typ_q      <= TYP_BIT;
      dat_q      <= 1'b0;
      ovd_q      <= 1'b0;
      pwr_q      <= 1'b0;
      sel_q      <= '0;
      sel_ok_q   <= 1'b0;
      sel_mask_q <= '0;
      tick_cnt   <= '0;
      owr_e_q    <= '0;
      owr_p_q    <= '0;
      smp_lvl    <= 1'b0;
      pwr_go     <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_dat_q  <= 1'b0;
    end else begin
      rsp_vld_q <= 1'b0;
      pwr_go    <= 1'b0;
      if (pwr_go) begin
        owr_p_q <= sel_mask_q;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            typ_q      <= cmd_typ_e'(bus.cmd_typ);
            dat_q      <= bus.cmd_dat;
            ovd_q      <= bus.cmd_ovd;
            pwr_q      <= bus.cmd_pwr;
            sel_q      <= bus.cmd_sel;
            sel_ok_q   <= sel_ok_in;
            sel_mask_q <= sel_mask_in;
            tick_cnt   <= '0;
            owr_p_q    <= '0;
            if (typ_is_slot(bus.cmd_typ)) begin
              state   <= ST_LOW;
              owr_e_q <= sel_mask_in;
            end else begin
              rsp_vld_q <= 1'b1;
              rsp_dat_q <= 1'b0;
            end
          end
        end
        default: begin
          if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == smp_pt - 10'd1) begin
              smp_lvl <= line;
              if (state == ST_REL) begin
                state <= ST_REC;
              end
            end
            // A long low time can outlast the sample point; skip REL then
            if (state == ST_LOW && tick_cnt == low_end - 10'd1) begin
              owr_e_q <= '0;
              state   <= (tick_cnt >= smp_pt - 10'd1) ? ST_REC : ST_REL;
            end
            if (tick_cnt == slot_end - 10'd1) begin
              state     <= ST_IDLE;
              rsp_vld_q <= 1'b1;
              rsp_dat_q <= (typ_q == TYP_RST) ? ~smp_lvl : smp_lvl;
              pwr_go    <= pwr_q;
            end
          end
        end
      endcase
    end
  end

  assign bus.cmd_rdy = (state == ST_IDLE);
  assign bus.rsp_vld = rsp_vld_q;
  assign bus.rsp_dat = rsp_dat_q;
  assign bus.owr_e   = owr_e_q;
  // Pull-up is already off in the cycle a new command is taken
  assign bus.owr_p   = owr_p_q & ~{OWN{accept}};

endmodule

// File: tb/tb_onewire_mc.sv
// tb/tb_onewire_mc.sv - scoreboard bench for onewire_mc
module tb_onewire_mc;
  localparam int OWN   = 4;
  localparam int CDR_N = 4;
  localparam int CDR_O = 1;

  typedef struct {
    int   cyc;
    logic dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  onewire_mc_if #(.OWN(OWN)) bus ();

  onewire_mc #(
    .OWN   (OWN),
    .CDR_N (CDR_N),
    .CDR_O (CDR_O)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  int         c0 = 0;
  int         cur_e_end = 0;
  int         cur_rsp = 0;
  logic       cur_pwr = 1'b0;
  logic [1:0] cur_sel = 2'd0;

  int             lo_from = 0;
  int             lo_to = 0;
  logic [OWN-1:0] lo_mask = '0;
  logic [OWN-1:0] ext_low = '0;

  int   e_mis = 0;
  int   p_mis = 0;
  int   ov_mis = 0;
  int   obs_wr = 0;
  int   obs_rd = 0;
  int   obs_cyc [256];
  logic obs_dat [256];

  assign bus.owr_i = ~(bus.owr_e | ext_low);

  always @(negedge clk) begin : mon
    int rel;
    logic [OWN-1:0] m;
    logic [OWN-1:0] ee;
    logic [OWN-1:0] ep;
    rel = cyc - c0;
    m   = OWN'(1) << cur_sel;
    ext_low = (rel >= lo_from && rel < lo_to) ? lo_mask : '0;
    if (!rst) begin
      ee = (rel >= 1 && rel <= cur_e_end) ? m : '0;
      ep = (cur_pwr && rel >= cur_rsp + 1) ? m : '0;
      if (bus.owr_e !== ee) e_mis = e_mis + 1;
      if (bus.owr_p !== ep) p_mis = p_mis + 1;
      if ((bus.owr_e & bus.owr_p) != '0) ov_mis = ov_mis + 1;
      if (bus.rsp_vld === 1'b1) begin
        obs_cyc[obs_wr % 256] = cyc;
        obs_dat[obs_wr % 256] = bus.rsp_dat;
        obs_wr = obs_wr + 1;
      end
    end
  end

  task automatic issue(input logic [1:0] typ, input logic dat, input logic ovd,
                       input logic pwr, input logic [1:0] sel, input logic exp_dat);
    int n;
    int dv;
    int t;
    int low;
    n = 0;
    @(posedge clk); #1;
    while (bus.cmd_rdy !== 1'b1 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL cmd_rdy_timeout: cmd_rdy=%0b, required 1", bus.cmd_rdy);
    end
    bus.cmd_vld = 1'b1;
    bus.cmd_typ = typ;
    bus.cmd_dat = dat;
    bus.cmd_ovd = ovd;
    bus.cmd_pwr = pwr;
    bus.cmd_sel = sel;
    dv = ovd ? CDR_O : CDR_N;
    if (typ == 2'b00) begin
      t = 64;
      low = dat ? 6 : 60;
    end else if (typ == 2'b01) begin
      t = 960;
      low = 480;
    end else begin
      t = 0;
      low = 0;
    end
    c0        = cyc;
    cur_sel   = sel;
    cur_e_end = low * dv;
    cur_rsp   = (typ[1]) ? 1 : t * dv + 1;
    cur_pwr   = pwr && !typ[1];
    sb.push_back('{c0 + cur_rsp, exp_dat});
    @(posedge clk); #1;
    bus.cmd_vld = 1'b0;
    bus.cmd_typ = 2'($urandom);
    bus.cmd_dat = 1'($urandom);
    bus.cmd_ovd = 1'($urandom);
    bus.cmd_pwr = 1'($urandom);
    bus.cmd_sel = 2'($urandom);
  endtask

  task automatic wait_rsp(input int budget);
    int n;
    exp_t x;
    n = 0;
    while ((obs_wr - obs_rd) < sb.size() && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    while (obs_rd < obs_wr) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: rsp at cycle %0d dat %0b, required none",
                 obs_cyc[obs_rd % 256], obs_dat[obs_rd % 256]);
      end else begin
        x = sb.pop_front();
        if (obs_cyc[obs_rd % 256] !== x.cyc || obs_dat[obs_rd % 256] !== x.dat) begin
          errors++;
          $display("FAIL rsp_match: cycle %0d dat %0b, required cycle %0d dat %0b",
                   obs_cyc[obs_rd % 256], obs_dat[obs_rd % 256], x.cyc, x.dat);
        end
      end
      obs_rd++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rsp_missing: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (bus.rsp_vld !== 1'b0) begin errors++; $display("FAIL reset_rsp_vld: %0b, required 0", bus.rsp_vld); end
    checks++;
    if (bus.rsp_dat !== 1'b0) begin errors++; $display("FAIL reset_rsp_dat: %0b, required 0", bus.rsp_dat); end
    checks++;
    if (bus.owr_e !== 4'b0000) begin errors++; $display("FAIL reset_owr_e: %b, required 0000", bus.owr_e); end
    checks++;
    if (bus.owr_p !== 4'b0000) begin errors++; $display("FAIL reset_owr_p: %b, required 0000", bus.owr_p); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL reset_cmd_rdy: %0b, required 1", bus.cmd_rdy); end
  endtask

  task automatic test_write0;
    int eb;
    eb = e_mis;
    issue(2'b00, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
    wait_rsp(400);
    checks++;
    if (e_mis !== eb) begin errors++; $display("FAIL write0_owr_e: %0d bad cycles, required 0", e_mis - eb); end
  endtask

  task automatic test_read;
    int eb;
    eb = e_mis;
    issue(2'b00, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
    lo_from = 10;
    lo_to   = 60;
    lo_mask = 4'b0010;
    wait_rsp(400);
    lo_mask = '0;
    issue(2'b00, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1);
    wait_rsp(400);
    checks++;
    if (e_mis !== eb) begin errors++; $display("FAIL read_owr_e: %0d bad cycles, required 0", e_mis - eb); end
  endtask

  task automatic test_presence;
    int eb;
    eb = e_mis;
    issue(2'b01, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    lo_from = 2000;
    lo_to   = 2600;
    lo_mask = 4'b0001;
    wait_rsp(4200);
    lo_mask = '0;
    issue(2'b01, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    wait_rsp(4200);
    checks++;
    if (e_mis !== eb) begin errors++; $display("FAIL presence_owr_e: %0d bad cycles, required 0", e_mis - eb); end
  endtask

  task automatic test_overdrive_pwr;
    int eb;
    int pb;
    int ob;
    eb = e_mis;
    pb = p_mis;
    ob = ov_mis;
    issue(2'b00, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1);
    wait_rsp(200);
    repeat (10) begin
      @(posedge clk); #1;
    end
    checks++;
    if (bus.owr_p !== 4'b1000) begin errors++; $display("FAIL pwr_on: owr_p=%b, required 1000", bus.owr_p); end
    issue(2'b00, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    wait_rsp(400);
    checks++;
    if (e_mis !== eb) begin errors++; $display("FAIL ovd_owr_e: %0d bad cycles, required 0", e_mis - eb); end
    checks++;
    if (p_mis !== pb) begin errors++; $display("FAIL pwr_window: %0d bad cycles, required 0", p_mis - pb); end
    checks++;
    if (ov_mis !== ob) begin errors++; $display("FAIL pwr_overlap: %0d cycles, required 0", ov_mis - ob); end
  endtask

  task automatic test_reserved;
    int eb;
    int pb;
    eb = e_mis;
    pb = p_mis;
    issue(2'b10, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
    wait_rsp(20);
    issue(2'b11, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0);
    wait_rsp(20);
    checks++;
    if (e_mis !== eb || p_mis !== pb) begin
      errors++;
      $display("FAIL reserved_lines: %0d/%0d bad cycles, required 0/0", e_mis - eb, p_mis - pb);
    end
  endtask

  task automatic test_busy_ignore;
    int eb;
    eb = e_mis;
    issue(2'b00, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    bus.cmd_vld = 1'b1;
    bus.cmd_typ = 2'b00;
    bus.cmd_dat = 1'b0;
    bus.cmd_sel = 2'd3;
    repeat (150) begin
      @(posedge clk); #1;
    end
    checks++;
    if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL busy_cmd_rdy: %0b, required 0", bus.cmd_rdy); end
    bus.cmd_vld = 1'b0;
    wait_rsp(400);
    checks++;
    if (e_mis !== eb) begin errors++; $display("FAIL busy_owr_e: %0d bad cycles, required 0", e_mis - eb); end
  endtask

  task automatic test_rst_mid;
    int base;
    issue(2'b01, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    while (cyc - c0 < 100) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    cur_e_end = 0;
    cur_pwr = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (bus.owr_e !== 4'b0000 || bus.owr_p !== 4'b0000 || bus.rsp_vld !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs: owr_e=%b owr_p=%b rsp_vld=%0b, required 0000 0000 0",
               bus.owr_e, bus.owr_p, bus.rsp_vld);
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    base = obs_wr;
    repeat (4000) begin
      @(posedge clk); #1;
    end
    checks++;
    if (obs_wr !== base) begin errors++; $display("FAIL rst_mid_rsp: %0d pulses, required 0", obs_wr - base); end
    obs_rd = obs_wr;
    checks++;
    if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL rst_mid_cmd_rdy: %0b, required 1", bus.cmd_rdy); end
    issue(2'b00, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0);
    wait_rsp(200);
  endtask

  initial begin
    bus.cmd_vld = 1'b0;
    bus.cmd_typ = 2'b00;
    bus.cmd_dat = 1'b0;
    bus.cmd_ovd = 1'b0;
    bus.cmd_pwr = 1'b0;
    bus.cmd_sel = 2'd0;
    test_reset();
    test_write0();
    test_read();
    test_presence();
    test_overdrive_pwr();
    test_reserved();
    test_busy_ignore();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
